// File: rtl/jtag_scan_master.sv
// jtag_scan_master: command-driven JTAG master for TAP reset, IR/DR scans and idle clocking.
// Define JTAG_SCAN_TDO_SYNC_EN to pass tdo_i through a 2-flop synchronizer before sampling.
module jtag_scan_master #(
  parameter int MaxScanLen = 64,
  parameter int ClkDivHalf = 5,
  parameter int ResetTmsCycles = 5
) (
  input  logic                              clk_sys_i,
  input  logic                              rst_sys_i,
  input  logic                              cmd_valid_i,
  output logic                              cmd_ready_o,
  input  logic [1:0]                        cmd_op_i,
  input  logic [$clog2(MaxScanLen+1)-1:0]   cmd_len_i,
  input  logic [MaxScanLen-1:0]             cmd_data_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [MaxScanLen-1:0]             rsp_data_o,
  output logic                              rsp_err_o,
  output logic                              tap_synced_o,
  output logic                              tck_o,
  output logic                              tms_o,
  output logic                              tdi_o,
  output logic                              trst_no,
  input  logic                              tdo_i
);
  localparam int LW = $clog2(MaxScanLen + 1);
  localparam int IW = $clog2(MaxScanLen);
  localparam int CW = $clog2(MaxScanLen + ResetTmsCycles + 1);
  localparam int DW = $clog2(ClkDivHalf);
  localparam logic [2:0] IDLE = 3'd0, TRST = 3'd1, PRE = 3'd2, SHIFT = 3'd3, POST = 3'd4, RUNI = 3'd5, RESP = 3'd6;
  localparam logic [1:0] OP_RESET = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2, OP_RUN = 2'd3;
  logic [2:0] state;
  logic [1:0] op;
  logic [LW-1:0] len;
  logic [MaxScanLen-1:0] data, cap;
  logic [CW-1:0] cnt, last_cnt;
  logic [DW-1:0] div;
  logic [IW-1:0] idx;
  logic tck, err, synced, tdo_s, active, half_end, bit_end, last, reject;
`ifdef JTAG_SCAN_TDO_SYNC_EN
  logic [1:0] tdo_q;
  always_ff @(posedge clk_sys_i) tdo_q <= rst_sys_i ? 2'b00 : {tdo_q[0], tdo_i};
  assign tdo_s = tdo_q[1];
  if (ClkDivHalf < 3) begin : g_div_chk
    $error("ClkDivHalf must be at least 3 when the TDO synchronizer is enabled");
  end
`else
  assign tdo_s = tdo_i;
`endif
  always_comb begin
    idx = cnt[IW-1:0];
    active = state inside {TRST, PRE, SHIFT, POST, RUNI};
    half_end = div == DW'(ClkDivHalf - 1);
    bit_end = active && tck && half_end;
    last_cnt = state == TRST ? CW'(ResetTmsCycles - 1) :
               state == PRE ? (op == OP_IR ? CW'(3) : CW'(2)) :
               state == POST ? CW'(1) : CW'(len) - CW'(1);
    last = cnt == last_cnt;
    reject = (cmd_op_i == OP_IR || cmd_op_i == OP_DR) &&
             (cmd_len_i == '0 || cmd_len_i > LW'(MaxScanLen) || !synced);
    tms_o = state == TRST ? 1'b1 :
            state == PRE ? (op == OP_IR ? cnt < CW'(2) : cnt == '0) :
            state == SHIFT ? last :
            state == POST ? cnt == '0 : state != RUNI;
    tdi_o = state == SHIFT && data[idx];
    trst_no = state != TRST;
    tck_o = tck;
    cmd_ready_o = state == IDLE && !rst_sys_i;
    rsp_valid_o = state == RESP;
    rsp_data_o = cap;
    rsp_err_o = err;
    tap_synced_o = synced;
  end
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state <= IDLE;
      op <= '0;
      len <= '0;
      data <= '0;
      cap <= '0;
      cnt <= '0;
      div <= '0;
      tck <= 1'b0;
      err <= 1'b0;
      synced <= 1'b0;
    end else begin
      if (active) begin
        div <= half_end ? '0 : div + 1'b1;
        if (half_end) tck <= ~tck;
      end
      if (bit_end) begin
        cnt <= last ? '0 : cnt + 1'b1;
        if (state == SHIFT) cap[idx] <= tdo_s;
        if (last) begin
          state <= state == TRST ? RUNI : state == PRE ? SHIFT : state == SHIFT ? POST : RESP;
          if (state == TRST) len <= LW'(1);
          if (state == RUNI && op == OP_RESET) synced <= 1'b1;
        end
      end
      if (state == IDLE && cmd_valid_i) begin
        op <= cmd_op_i;
        len <= cmd_len_i;
        data <= cmd_data_i;
        cap <= '0;
        cnt <= '0;
        div <= '0;
        err <= reject;
        if (cmd_op_i == OP_RESET) synced <= 1'b0;
        state <= cmd_op_i == OP_RESET ? TRST :
                 (reject || cmd_len_i == '0) ? RESP :
                 cmd_op_i == OP_RUN ? RUNI : PRE;
      end
      if (state == RESP && rsp_ready_i) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: directed bench for jtag_scan_master with TCK/TMS/TRST monitors and a TDO model.
module tb_jtag_scan_master;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b0, loop = 1'b0;
  logic cmd_ready, rsp_valid, rsp_err, synced, tck, tms, tdi, trst_n, tdo;
  logic [1:0] cmd_op = '0;
  logic [6:0] cmd_len = '0;
  logic [63:0] cmd_data = '0, rsp_data, tms_log = '0;
  logic [63:0] pat = 64'hA5A5A5A5_5A5A5A5A;
  int tck_rises = 0, trst_low = 0, tck_base = 0, trst_base = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  jtag_scan_master dut (
    .clk_sys_i(clk), .rst_sys_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_len_i(cmd_len), .cmd_data_i(cmd_data), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err), .tap_synced_o(synced),
    .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .trst_no(trst_n), .tdo_i(tdo)
  );
  // TDO model: shift bit k is sampled after the (4+k)-th TCK rise of a DR scan
  always_comb tdo = loop ? tdi : (tck_rises - tck_base >= 4 && tck_rises - tck_base < 68) ? pat[tck_rises - tck_base - 4] : 1'b0;
  always @(posedge tck) begin
    tck_rises++;
    tms_log = {tms_log[62:0], tms};
  end
  always @(negedge clk) if (!trst_n) trst_low++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [1:0] op, input int len, input logic [63:0] d);
    int n = 0;
    @(negedge clk);
    cmd_op = op;
    cmd_len = 7'(len);
    cmd_data = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready", cmd_ready, 1);
    tck_base = tck_rises;
    trst_base = trst_low;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic wait_rsp(input int lim, output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
    chk("rsp_valid", rsp_valid, 1);
  endtask
  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
  endtask
  initial begin
    int cyc;
    logic seen;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_trst", trst_n, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_synced", synced, 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", cmd_ready, 1);
    send(2'd1, 5, 64'h11);
    wait_rsp(50, cyc);
    chk("unsync_err", rsp_err, 1);
    chk("unsync_data", rsp_data, 0);
    chk("unsync_tck", tck_rises - tck_base, 0);
    consume();
    send(2'd0, 0, 64'h0);
    wait_rsp(200, cyc);
    chk("reset_trst_clk", trst_low - trst_base, 50);
    chk("reset_tck", tck_rises - tck_base, 6);
    chk("reset_tms", tms_log & 64'h3F, 64'h3E);
    chk("reset_synced", synced, 1);
    chk("reset_err", rsp_err, 0);
    consume();
    loop = 1'b1;
    send(2'd1, 5, 64'h11);
    wait_rsp(300, cyc);
    chk("ir_tck", tck_rises - tck_base, 11);
    chk("ir_tms", tms_log & 64'h7FF, 64'h606);
    chk("ir_data", rsp_data, 64'h11);
    chk("ir_err", rsp_err, 0);
    consume();
    loop = 1'b0;
    send(2'd2, 64, 64'hDEADBEEF_01234567);
    wait_rsp(1000, cyc);
    chk("dr_tck", tck_rises - tck_base, 69);
    chk("dr_tms_tail", tms_log, 64'h6);
    chk("dr_data", rsp_data, pat);
    repeat (20) @(negedge clk);
    chk("dr_hold_valid", rsp_valid, 1);
    chk("dr_hold_data", rsp_data, pat);
    consume();
    send(2'd3, 0, 64'h0);
    wait_rsp(3, cyc);
    chk("ri0_fast", cyc <= 2, 1);
    chk("ri0_tck", tck_rises - tck_base, 0);
    consume();
    send(2'd3, 8, 64'h0);
    wait_rsp(200, cyc);
    chk("ri8_tck", tck_rises - tck_base, 8);
    chk("ri8_tms", tms_log & 64'hFF, 0);
    chk("ri8_err", rsp_err, 0);
    consume();
    send(2'd2, 0, 64'h0);
    wait_rsp(10, cyc);
    chk("dr_len0_err", rsp_err, 1);
    chk("dr_len0_tck", tck_rises - tck_base, 0);
    chk("dr_len0_synced", synced, 1);
    consume();
    send(2'd2, 65, 64'h0);
    wait_rsp(10, cyc);
    chk("dr_len65_err", rsp_err, 1);
    chk("dr_len65_data", rsp_data, 0);
    chk("dr_len65_synced", synced, 1);
    consume();
    send(2'd2, 64, 64'h0F0F);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready_in_rst", cmd_ready, 0);
    rst = 1'b0;
    #1;
    chk("abort_tck", tck, 0);
    chk("abort_tms", tms, 1);
    chk("abort_tdi", tdi, 0);
    chk("abort_trst", trst_n, 1);
    chk("abort_valid", rsp_valid, 0);
    chk("abort_err", rsp_err, 0);
    chk("abort_data", rsp_data, 0);
    chk("abort_synced", synced, 0);
    chk("abort_ready", cmd_ready, 1);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    chk("abort_no_rsp", seen, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
